// File: rtl/mem_stage_if.sv
// Bundle of the EX/MEM-side, data-memory and MEM/WB-side signals of the MEM stage.
// The slave view belongs to the stage controller; the master view is its environment.
interface mem_stage_if #(
  parameter int DATA_LEN         = 64,
  parameter int CONTROL_LINE     = 2,
  parameter int INSTRUCTION_PART = 5
);
  logic                        ex_valid;
  logic                        ex_mem_read;
  logic                        ex_mem_write;
  logic [DATA_LEN-1:0]         ex_addr;
  logic [DATA_LEN-1:0]         ex_wdata;
  logic [CONTROL_LINE-1:0]     ex_ctrl;
  logic [INSTRUCTION_PART-1:0] ex_rd;
  logic                        dmem_req;
  logic                        dmem_we;
  logic [DATA_LEN-1:0]         dmem_addr;
  logic [DATA_LEN-1:0]         dmem_wdata;
  logic [DATA_LEN-1:0]         dmem_rdata;
  logic                        dmem_ack;
  logic                        stall;
  logic                        wb_valid;
  logic [DATA_LEN-1:0]         wb_addr;
  logic [DATA_LEN-1:0]         wb_data;
  logic [CONTROL_LINE-1:0]     wb_ctrl;
  logic [INSTRUCTION_PART-1:0] wb_rd;
  logic                        err_pulse;
  logic                        err_sticky;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, ex_ctrl, ex_rd,
    input  dmem_rdata, dmem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output stall, wb_valid, wb_addr, wb_data, wb_ctrl, wb_rd, err_pulse, err_sticky
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, ex_ctrl, ex_rd,
    output dmem_rdata, dmem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  stall, wb_valid, wb_addr, wb_data, wb_ctrl, wb_rd, err_pulse, err_sticky
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage sequencer: single-cycle pass-through for ALU ops, req/ack handshake
// with timeout for loads and stores, results handed to MEM/WB.
module mem_stage_ctrl #(
  parameter int DATA_LEN         = 64,
  parameter int CONTROL_LINE     = 2,
  parameter int INSTRUCTION_PART = 5,
  parameter int TIMEOUT          = 16
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                      state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        req_q;
  logic                        we_q;
  logic [DATA_LEN-1:0]         addr_q;
  logic [DATA_LEN-1:0]         wdata_q;
  logic [DATA_LEN-1:0]         data_q;
  logic [CONTROL_LINE-1:0]     ctrl_q;
  logic [INSTRUCTION_PART-1:0] rd_q;
  logic                        err_q;
  logic                        sticky_q;

  logic mem_op_d;
  assign mem_op_d = bus.ex_mem_read | bus.ex_mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ex_valid && mem_op_d) begin
            // A write flag wins when both are set, so we_q is just the store bit.
            addr_q  <= bus.ex_addr;
            wdata_q <= bus.ex_wdata;
            we_q    <= bus.ex_mem_write;
            ctrl_q  <= bus.ex_ctrl;
            rd_q    <= bus.ex_rd;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.dmem_ack) begin
            data_q  <= we_q ? '0 : bus.dmem_rdata;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            data_q   <= '0;
            err_q    <= 1'b1;
            sticky_q <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic                        stall_d;
  logic                        wb_valid_d;
  logic [DATA_LEN-1:0]         wb_addr_d;
  logic [DATA_LEN-1:0]         wb_data_d;
  logic [CONTROL_LINE-1:0]     wb_ctrl_d;
  logic [INSTRUCTION_PART-1:0] wb_rd_d;
  logic                        err_pulse_d;

  // Bubbles drive every wb_* field to zero, not just wb_valid/wb_ctrl.
  always_comb begin
    stall_d     = 1'b0;
    wb_valid_d  = 1'b0;
    wb_addr_d   = '0;
    wb_data_d   = '0;
    wb_ctrl_d   = '0;
    wb_rd_d     = '0;
    err_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (mem_op_d) begin
            stall_d = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_addr_d  = bus.ex_addr;
            wb_ctrl_d  = bus.ex_ctrl;
            wb_rd_d    = bus.ex_rd;
          end
        end
      end
      REQ: stall_d = 1'b1;
      DONE: begin
        wb_valid_d  = 1'b1;
        wb_addr_d   = addr_q;
        wb_data_d   = data_q;
        wb_ctrl_d   = ctrl_q;
        wb_rd_d     = rd_q;
        err_pulse_d = err_q;
      end
      default: stall_d = 1'b0;
    endcase
  end

  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.stall      = stall_d;
  assign bus.wb_valid   = wb_valid_d;
  assign bus.wb_addr    = wb_addr_d;
  assign bus.wb_data    = wb_data_d;
  assign bus.wb_ctrl    = wb_ctrl_d;
  assign bus.wb_rd      = wb_rd_d;
  assign bus.err_pulse  = err_pulse_d;
  assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, randomized ops against a
// transaction-level model, and hand-written reset / stray-ack sequences.
module tb_mem_stage_ctrl;
  localparam int DL = 64;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.DATA_LEN(DL), .CONTROL_LINE(2), .INSTRUCTION_PART(5)) bus ();

  mem_stage_ctrl #(
    .DATA_LEN(DL), .CONTROL_LINE(2), .INSTRUCTION_PART(5), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_sticky = 1'b0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  ctrl;
    logic [4:0]  rdest;
    logic [63:0] rdata;
    int          ack_delay;   // REQ cycle on which ack arrives; 0 = never
    int          exp_stall;
    int          exp_req;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ex_valid     = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_mem_write = 1'b0;
    bus.ex_addr      = '0;
    bus.ex_wdata     = '0;
    bus.ex_ctrl      = '0;
    bus.ex_rd        = '0;
    bus.dmem_ack     = 1'b0;
    bus.dmem_rdata   = '0;
  endtask

  // Called at a negedge; returns at the negedge after the op retires.
  task automatic run_op(input vec_t v, input string tag);
    int stall_cnt = 0;
    int req_cnt = 0;
    int errp_cnt = 0;
    logic stable = 1'b1;
    logic got = 1'b0;
    logic [63:0] g_addr = '0, g_data = '0;
    logic [1:0] g_ctrl = '0;
    logic [4:0] g_rd = '0;
    logic g_sticky = 1'b0;
    bus.ex_valid     = 1'b1;
    bus.ex_mem_read  = v.rd;
    bus.ex_mem_write = v.wr;
    bus.ex_addr      = v.addr;
    bus.ex_wdata     = v.wdata;
    bus.ex_ctrl      = v.ctrl;
    bus.ex_rd        = v.rdest;
    for (int cyc = 0; cyc < 64 && !got; cyc++) begin
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = {$urandom, $urandom};
      if (bus.dmem_req) begin
        req_cnt++;
        if (req_cnt == v.ack_delay) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = v.rdata;
        end
        if (bus.dmem_addr !== v.addr || bus.dmem_wdata !== v.wdata || bus.dmem_we !== v.wr)
          stable = 1'b0;
      end
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.err_pulse) errp_cnt++;
      if (bus.wb_valid) begin
        got      = 1'b1;
        g_addr   = bus.wb_addr;
        g_data   = bus.wb_data;
        g_ctrl   = bus.wb_ctrl;
        g_rd     = bus.wb_rd;
        g_sticky = bus.err_sticky;
      end
      @(posedge clk);
      @(negedge clk);
    end
    idle_inputs();
    exp_sticky = exp_sticky | v.exp_err;
    chk({tag, " wb_seen"}, 64'(got), 64'd1);
    chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(v.exp_stall));
    chk({tag, " req_cycles"}, 64'(req_cnt), 64'(v.exp_req));
    chk({tag, " wb_addr"}, g_addr, v.addr);
    chk({tag, " wb_data"}, g_data, v.exp_data);
    chk({tag, " wb_ctrl"}, 64'(g_ctrl), 64'(v.ctrl));
    chk({tag, " wb_rd"}, 64'(g_rd), 64'(v.rdest));
    chk({tag, " err_pulse_cycles"}, 64'(errp_cnt), 64'(v.exp_err));
    chk({tag, " err_sticky"}, 64'(g_sticky), 64'(exp_sticky));
    if (v.exp_req > 0) chk({tag, " req_stable"}, 64'(stable), 64'd1);
    $display("op %s rd=%0b wr=%0b addr=%0h stall=%0d req=%0d data=%0h err=%0d",
             tag, v.rd, v.wr, v.addr, stall_cnt, req_cnt, g_data, errp_cnt);
  endtask

  // Transaction-level reference: cost and result of one op from the stage rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic timed_out;
    if (!(v.rd || v.wr)) begin
      r.exp_stall = 0;
      r.exp_req   = 0;
      r.exp_data  = '0;
      r.exp_err   = 1'b0;
    end else begin
      timed_out   = (v.ack_delay == 0) || (v.ack_delay > TO);
      r.exp_req   = timed_out ? TO : v.ack_delay;
      r.exp_stall = r.exp_req + 1;
      r.exp_data  = (timed_out || v.wr) ? 64'd0 : v.rdata;
      r.exp_err   = timed_out;
    end
    return r;
  endfunction

  initial begin
    vec_t rv;
    idle_inputs();
    vecs[0] = '{1'b0, 1'b0, 64'h1234, 64'h0, 2'b10, 5'd5, 64'h0, 0, 0, 0, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 64'h40, 64'h0, 2'b01, 5'd7, 64'hDEADBEEF, 1, 2, 1, 64'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 64'h80, 64'h55, 2'b11, 5'd0, 64'h1111, 3, 4, 3, 64'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 64'h100, 64'h0, 2'b01, 5'd9, 64'hABCD, 0, 17, 16, 64'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 64'h108, 64'h0, 2'b10, 5'd10, 64'hCAFEF00D, 16, 17, 16, 64'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 64'h200, 64'h77, 2'b01, 5'd3, 64'h9999, 2, 3, 2, 64'h0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset outputs", {bus.dmem_req, bus.dmem_we, bus.stall, bus.wb_valid, bus.err_pulse,
                          bus.err_sticky, bus.wb_ctrl, bus.wb_rd}, 64'd0);
    chk("reset dmem_addr", bus.dmem_addr | bus.dmem_wdata, 64'd0);
    chk("reset wb_buses", bus.wb_addr | bus.wb_data, 64'd0);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.rd        = ($urandom_range(0, 3) != 0);
      rv.wr        = ($urandom_range(0, 2) == 0);
      rv.addr      = {$urandom, $urandom};
      rv.wdata     = {$urandom, $urandom};
      rv.ctrl      = 2'($urandom);
      rv.rdest     = 5'($urandom);
      rv.rdata     = {$urandom, $urandom};
      rv.ack_delay = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 2);
      if (!(rv.rd || rv.wr)) rv.wdata = '0;
      rv = model(rv);
      run_op(rv, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    // Reset on the second REQ cycle of a load; a late ack must be ignored.
    bus.ex_valid    = 1'b1;
    bus.ex_mem_read = 1'b1;
    bus.ex_addr     = 64'h300;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    exp_sticky = 1'b0;
    #1;
    chk("rst_mid dmem_req", 64'(bus.dmem_req), 64'd0);
    chk("rst_mid stall", 64'(bus.stall), 64'd0);
    chk("rst_mid wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_mid err_sticky", 64'(bus.err_sticky), 64'd0);
    $display("seq reset mid-op done");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.dmem_ack   = (c == 0);
      bus.dmem_rdata = 64'h5A5A;
      #1;
      chk($sformatf("late_ack c%0d", c), {bus.dmem_req, bus.stall, bus.wb_valid}, 64'd0);
    end
    bus.dmem_ack = 1'b0;
    @(negedge clk);

    // Stray ack in IDLE, then a load followed back-to-back by an ALU op.
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 64'hBAD;
    #1;
    chk("stray_ack idle", {bus.dmem_req, bus.stall, bus.wb_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    chk("stray_ack after", {bus.dmem_req, bus.stall, bus.wb_valid, bus.err_sticky}, 64'd0);
    $display("seq stray ack done");
    @(negedge clk);
    rv = '{1'b1, 1'b0, 64'h440, 64'h0, 2'b11, 5'd12, 64'h0123456789ABCDEF, 2, 0, 0, 64'h0, 1'b0};
    run_op(model(rv), "b2b_load");
    rv = '{1'b0, 1'b0, 64'h9876, 64'h0, 2'b01, 5'd13, 64'h0, 0, 0, 0, 64'h0, 1'b0};
    run_op(model(rv), "b2b_alu");
    #1;
    chk("b2b no extra wb", 64'(bus.wb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage of the pipelined RISC-V core. It sits between the EX/MEM register outputs and the MEM/WB pipeline register.
- Passes non-memory ops straight through in one cycle.
- For loads and stores, runs a req/ack handshake with the data memory, stalls upstream stages until the access completes, and presents the result to MEM/WB.
- Bounds every access with a timeout and reports an error if the memory never answers.

Parameters:
- DATA_LEN, 64, width of address/data paths
- CONTROL_LINE, 2, width of WB control bits carried through
- INSTRUCTION_PART, 5, width of destination register field
- TIMEOUT, 16, maximum cycles spent waiting for dmem_ack (>=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid op
- ex_mem_read  in  1  op is a load
- ex_mem_write  in  1  op is a store
- ex_addr  in  DATA_LEN  ALU result / memory address
- ex_wdata  in  DATA_LEN  store data
- ex_ctrl  in  CONTROL_LINE  WB control bits
- ex_rd  in  INSTRUCTION_PART  destination register
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1=write, registered
- dmem_addr  out  DATA_LEN  registered request address
- dmem_wdata  out  DATA_LEN  registered store data
- dmem_rdata  in  DATA_LEN  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- stall  out  1  hold IF/ID, ID/EX, EX/MEM
- wb_valid  out  1  MEM/WB captures a real op this cycle (0 = bubble)
- wb_addr  out  DATA_LEN  ALU result/address to MEM/WB
- wb_data  out  DATA_LEN  load data (0 for non-loads and errors)
- wb_ctrl  out  CONTROL_LINE  WB control (0 when wb_valid=0)
- wb_rd  out  INSTRUCTION_PART  destination register
- err_pulse  out  1  one-cycle timeout flag, aligned with wb_valid
- err_sticky  out  1  set on any timeout, cleared only by rst

Behaviour:
- Reset: state IDLE, timeout count 0, all captured registers 0. Every output is 0.
- FSM states: IDLE, REQ, DONE.
- IDLE, ex_valid=0:
  - stall=0, wb_valid=0, wb_ctrl=0.
- IDLE, ex_valid=1, no memory op:
  - Combinational pass-through in the same cycle: wb_valid=1, wb_addr=ex_addr, wb_ctrl=ex_ctrl, wb_rd=ex_rd, wb_data=0, stall=0.
- IDLE, ex_valid=1, memory op:
  - stall=1 and wb_valid=0 this cycle.
  - Capture addr, wdata, ctrl, rd and we into registers; next state is REQ.
  - If ex_mem_read and ex_mem_write are both set, the store takes priority: we=1.
- REQ:
  - dmem_req=1 for every cycle in REQ; dmem_addr, dmem_wdata and dmem_we are held stable.
  - stall=1, wb_valid=0. The timeout counter increments each REQ cycle.
  - On dmem_ack=1: latch dmem_rdata (loads only; stores latch 0) and go to DONE.
  - If the counter reaches TIMEOUT-1 with no ack: go to DONE with the error flag set and data forced to 0. REQ therefore lasts at most TIMEOUT cycles.
  - An ack on the final timeout cycle wins; no error is raised.
- DONE, one cycle:
  - stall=0, wb_valid=1; wb_* driven from the captured registers.
  - err_pulse=1 if timed out; err_sticky sets on the same edge.
  - Next state IDLE. The next op appears on the ex_* inputs in the following cycle.
- dmem_ack outside REQ is ignored.
- Minimum memory-op cost: IDLE accept cycle + 1 REQ cycle, i.e. 2 stall cycles, with wb_valid in the third cycle.
- Reset mid-operation: the rst edge forces IDLE and dmem_req=0 on that edge. The in-flight op is dropped with no wb_valid; err_sticky clears.
- The counter resets to 0 on every entry to REQ.

Test Plan:
- Reset, then an ALU op (ex_valid=1, ex_addr=0x1234, ex_ctrl=2'b10, ex_rd=5) -> same cycle wb_valid=1, wb_addr=0x1234, wb_ctrl=2'b10, wb_rd=5, stall=0, dmem_req never rises.
- Load at addr 0x40, memory acks in the first REQ cycle with rdata=0xDEADBEEF -> stall high exactly 2 cycles, dmem_req high 1 cycle, then wb_valid=1, wb_data=0xDEADBEEF, wb_addr=0x40.
- Store to 0x80 with wdata=0x55, ack after 3 REQ cycles -> dmem_we=1, dmem_addr/wdata stable for all 3 cycles, stall high 4 cycles, wb_valid=1 with wb_data=0.
- Load, ack never arrives, TIMEOUT=16 -> dmem_req high exactly 16 cycles, then wb_valid=1, wb_data=0, err_pulse=1 for 1 cycle, err_sticky stays 1 until rst. Repeat with ack on the 16th REQ cycle -> no error, data latched.
- rst asserted on the 2nd REQ cycle of a load -> next cycle dmem_req=0, stall=0, wb_valid=0, err_sticky=0; a later ack is ignored.
- Back-to-back load then ALU op; plus ack pulsed while in IDLE -> both ops retire in order, with exactly one wb_valid each, and the stray ack has no effect.
